eeg_band_power_detector: RTL and testbench

//   Consumes the band-passed EEG sample stream, one sample per valid strobe.

---
 rtl/eeg_band_power_detector_if.sv | 23 ++
 rtl/eeg_band_power_detector.sv | 105 ++++++++++
 tb/tb_eeg_band_power_detector.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/eeg_band_power_detector_if.sv
// Sample stream in, windowed power and burst-event status out.
// master drives samples/threshold/clear; slave is the detector.
interface eeg_band_power_detector_if;
  logic               valid;
  logic signed [15:0] x_in;
  logic        [31:0] thresh;
  logic               clear;
  logic        [31:0] power_out;
  logic               power_valid;
  logic               event_pulse;
  logic               event_active;
  logic        [1:0]  state_dbg;

  modport master (
    output valid, x_in, thresh, clear,
    input  power_out, power_valid, event_pulse, event_active, state_dbg
  );

  modport slave (
    input  valid, x_in, thresh, clear,
    output power_out, power_valid, event_pulse, event_active, state_dbg
  );
endinterface

// File: rtl/eeg_band_power_detector.sv
// Windowed mean-square power of an EEG sample stream with a hold-off burst detector.
// power_valid two clocks after a window's last sample; 1 sample/clk, no backpressure.
module eeg_band_power_detector #(
  parameter int WIN_LOG2     = 6,
  parameter int HOLD_WINDOWS = 4,
  parameter int ACC_W        = 40
) (
  input  logic                       clk,
  input  logic                       rst_n,
  eeg_band_power_detector_if.slave   bus
);
  localparam logic [1:0] ARMED  = 2'd0;
  localparam logic [1:0] ACTIVE = 2'd1;
  localparam logic [1:0] HOLD   = 2'd2;

  logic signed [31:0]     prod;
  logic        [31:0]     sq_r;
  logic                   sq_v;
  logic [ACC_W-1:0]       acc;
  logic [ACC_W-1:0]       acc_nxt;
  logic [WIN_LOG2-1:0]    smp_cnt;
  logic [31:0]            power_r;
  logic                   pv_r;
  logic                   pv;
  logic                   hot;
  logic [1:0]             state;
  logic [7:0]             hold_cnt;

  assign prod    = bus.x_in * bus.x_in;
  assign acc_nxt = acc + ACC_W'(sq_r);
  // A clear in the strobe cycle suppresses the result and any event it would raise.
  assign pv      = pv_r & ~bus.clear;
  assign hot     = power_r > bus.thresh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sq_r <= '0;
      sq_v <= 1'b0;
    end else if (bus.clear) begin
      sq_v <= 1'b0;
    end else begin
      sq_v <= bus.valid;
      if (bus.valid) sq_r <= prod;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      smp_cnt <= '0;
      power_r <= '0;
      pv_r    <= 1'b0;
    end else if (bus.clear) begin
      acc     <= '0;
      smp_cnt <= '0;
      power_r <= '0;
      pv_r    <= 1'b0;
    end else begin
      pv_r <= 1'b0;
      if (sq_v) begin
        smp_cnt <= smp_cnt + 1'b1;
        if (&smp_cnt) begin
          power_r <= 32'(acc_nxt >> WIN_LOG2);
          acc     <= '0;
          pv_r    <= 1'b1;
        end else begin
          acc <= acc_nxt;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ARMED;
      hold_cnt <= '0;
    end else if (bus.clear) begin
      state    <= ARMED;
      hold_cnt <= '0;
    end else if (pv) begin
      case (state)
        ARMED:  if (hot) state <= ACTIVE;
        ACTIVE: if (!hot) begin
                  state    <= HOLD;
                  hold_cnt <= 8'(HOLD_WINDOWS);
                end
        HOLD:   if (hot) begin
                  state <= ACTIVE;
                end else if (hold_cnt == 8'd1) begin
                  state    <= ARMED;
                  hold_cnt <= '0;
                end else begin
                  hold_cnt <= hold_cnt - 1'b1;
                end
        default: state <= ARMED;
      endcase
    end
  end

  assign bus.power_out    = power_r;
  assign bus.power_valid  = pv;
  assign bus.event_pulse  = pv & hot & (state == ARMED);
  assign bus.event_active = (state != ARMED);
  assign bus.state_dbg    = state;
endmodule

// File: tb/tb_eeg_band_power_detector.sv
// Directed window table plus randomized stream checked against a window-level power/burst model.
module tb_eeg_band_power_detector;
  localparam int WIN  = 64;
  localparam int HOLD = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   pv_seen = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  eeg_band_power_detector_if bus();

  eeg_band_power_detector #(.WIN_LOG2(6), .HOLD_WINDOWS(HOLD), .ACC_W(40)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int          due;
    logic [31:0] power;
    logic        pulse;
    logic [1:0]  st;
  } exp_t;

  typedef struct {
    logic signed [15:0] x;
    logic [31:0]        thresh;
    logic [31:0]        power;
    logic               pulse;
    logic [1:0]         st;
  } vec_t;

  exp_t            exp_q[$];
  longint unsigned samp_q[$];
  int              m_mode = 0;   // 0 armed, 1 active, 2 hold
  int              m_quiet = 0;
  logic            chk_pending = 1'b0;
  logic [1:0]      pend_st;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Window-level model: every 64 accepted samples yield mean square and burst state.
  task automatic model_sample(input logic signed [15:0] x);
    longint unsigned sum;
    exp_t e;
    logic hot;
    int xi;
    xi = x;
    samp_q.push_back(longint'(xi) * longint'(xi));
    if (samp_q.size() == WIN) begin
      sum = 0;
      foreach (samp_q[i]) sum += samp_q[i];
      samp_q.delete();
      e.power = 32'(sum / WIN);
      hot     = e.power > bus.thresh;
      e.pulse = 1'b0;
      if (m_mode == 0) begin
        if (hot) begin m_mode = 1; e.pulse = 1'b1; end
      end else if (hot) begin
        m_mode = 1;
      end else if (m_mode == 1) begin
        m_mode = 2; m_quiet = HOLD;
      end else begin
        m_quiet--;
        if (m_quiet == 0) m_mode = 0;
      end
      e.st  = 2'(m_mode);
      e.due = cyc + 2;
      exp_q.push_back(e);
    end
  endtask

  task automatic model_flush();
    samp_q.delete();
    exp_q.delete();
    m_mode = 0;
    m_quiet = 0;
    chk_pending = 1'b0;
  endtask

  task automatic put(input logic signed [15:0] x);
    bus.valid = 1'b1;
    bus.x_in  = x;
    model_sample(x);
    tick();
    bus.valid = 1'b0;
  endtask

  task automatic do_clear(input logic with_valid, input logic signed [15:0] x);
    bus.clear = 1'b1;
    bus.valid = with_valid;
    bus.x_in  = x;
    model_flush();
    tick();
    bus.clear = 1'b0;
    bus.valid = 1'b0;
  endtask

  always @(negedge clk) begin
    #3;
    if (rst_n) begin
      if (chk_pending) begin
        chk_pending = 1'b0;
        check("mon_state", 32'(bus.state_dbg), 32'(pend_st));
        check("mon_active", 32'(bus.event_active), 32'(pend_st != 2'd0));
      end
      if (bus.power_valid) pv_seen++;
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        exp_t e;
        e = exp_q.pop_front();
        check("mon_pvalid", 32'(bus.power_valid), 32'd1);
        check("mon_power", bus.power_out, e.power);
        check("mon_pulse", 32'(bus.event_pulse), 32'(e.pulse));
        chk_pending = 1'b1;
        pend_st = e.st;
      end else if (bus.power_valid) begin
        check("mon_unexpected_pvalid", 32'd1, 32'd0);
      end
      if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
        check("mon_overdue_pvalid", 32'd0, 32'd1);
        void'(exp_q.pop_front());
      end
    end
  end

  vec_t tbl[10];

  initial begin
    int seen0;
    tbl[0] = '{16'sd256,    32'd100000,     32'd65536,      1'b0, 2'd0};
    tbl[1] = '{-16'sd32768, 32'h0FFFFFFF,   32'h40000000,   1'b1, 2'd1};
    tbl[2] = '{16'sd0,      32'h0FFFFFFF,   32'd0,          1'b0, 2'd2};
    tbl[3] = '{16'sd0,      32'h0FFFFFFF,   32'd0,          1'b0, 2'd2};
    tbl[4] = '{16'sd0,      32'h0FFFFFFF,   32'd0,          1'b0, 2'd2};
    tbl[5] = '{16'sd0,      32'h0FFFFFFF,   32'd0,          1'b0, 2'd2};
    tbl[6] = '{16'sd0,      32'h0FFFFFFF,   32'd0,          1'b0, 2'd0};
    tbl[7] = '{-16'sd32768, 32'h0FFFFFFF,   32'h40000000,   1'b1, 2'd1};
    tbl[8] = '{16'sd0,      32'h0FFFFFFF,   32'd0,          1'b0, 2'd2};
    tbl[9] = '{-16'sd32768, 32'h0FFFFFFF,   32'h40000000,   1'b0, 2'd1};

    rst_n = 1'b0;
    bus.valid = 1'b0; bus.x_in = '0; bus.thresh = '0; bus.clear = 1'b0;
    tick(); tick();
    check("rst_power", bus.power_out, 32'd0);
    check("rst_pvalid", 32'(bus.power_valid), 32'd0);
    check("rst_state", 32'(bus.state_dbg), 32'd0);
    rst_n = 1'b1;
    tick();

    // Directed windows: latency, threshold, event, hold countdown, re-trigger.
    foreach (tbl[v]) begin
      bus.thresh = tbl[v].thresh;
      for (int i = 0; i < WIN; i++) put(tbl[v].x);
      check($sformatf("v%0d_pvalid_early", v), 32'(bus.power_valid), 32'd0);
      tick();
      check($sformatf("v%0d_pvalid", v), 32'(bus.power_valid), 32'd1);
      check($sformatf("v%0d_power", v), bus.power_out, tbl[v].power);
      check($sformatf("v%0d_pulse", v), 32'(bus.event_pulse), 32'(tbl[v].pulse));
      tick();
      check($sformatf("v%0d_pvalid_after", v), 32'(bus.power_valid), 32'd0);
      check($sformatf("v%0d_state", v), 32'(bus.state_dbg), 32'(tbl[v].st));
      check($sformatf("v%0d_active", v), 32'(bus.event_active), 32'(tbl[v].st != 2'd0));
    end

    // Async reset mid-window while ACTIVE: everything drops at once, partial window lost.
    for (int i = 0; i < 20; i++) put(-16'sd32768);
    rst_n = 1'b0;
    model_flush();
    #1;
    check("arst_power", bus.power_out, 32'd0);
    check("arst_pvalid", 32'(bus.power_valid), 32'd0);
    check("arst_pulse", 32'(bus.event_pulse), 32'd0);
    check("arst_active", 32'(bus.event_active), 32'd0);
    check("arst_state", 32'(bus.state_dbg), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    bus.thresh = 32'd0;
    seen0 = pv_seen;
    for (int i = 0; i < WIN - 1; i++) put(16'sd100);
    repeat (4) tick();
    check("arst_no_early_window", 32'(pv_seen - seen0), 32'd0);
    put(16'sd100);
    repeat (3) tick();
    check("arst_full_window", 32'(pv_seen - seen0), 32'd1);
    check("arst_power_after", bus.power_out, 32'd10000);

    // Clear coincident with a valid discards the partial window and that sample.
    bus.thresh = 32'hFFFFFFFF;
    for (int i = 0; i < 30; i++) put(16'sd1000);
    do_clear(1'b1, 16'sd1000);
    check("clr_state", 32'(bus.state_dbg), 32'd0);
    check("clr_power_zero", bus.power_out, 32'd0);
    seen0 = pv_seen;
    for (int i = 0; i < WIN; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      put(16'sd16);
    end
    repeat (4) tick();
    check("clr_one_pvalid", 32'(pv_seen - seen0), 32'd1);
    check("clr_power", bus.power_out, 32'd256);

    // Randomized windows with random gaps, thresholds and one mid-window clear.
    for (int w = 0; w < 12; w++) begin
      int sh;
      bus.thresh = $urandom >> $urandom_range(2, 14);
      sh = $urandom_range(0, 12);
      for (int i = 0; i < WIN; i++) begin
        logic [15:0] r;
        r = 16'($urandom);
        repeat ($urandom_range(0, 2)) tick();
        if (w == 5 && i == 40) do_clear(1'($urandom), $signed(r));
        else put($signed(r) >>> sh);
      end
      repeat (3) tick();
    end
    repeat (4) tick();
    check("final_no_pending", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
